// File: rtl/add_seq_pkg.sv
// Shared definitions for add_seq: FSM state encoding and default operand size.
package add_seq_pkg;

    localparam int WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_seq_fa8.sv
// fa8: 8-bit combinational slice adder shared by all byte positions of add_seq.
module fa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] S,
    output logic       cout
);

    assign {cout, S} = {1'b0, a} + {1'b0, b} + {8'd0, ci};

endmodule

// File: rtl/add_seq.sv
// add_seq: multi-word adder that walks one byte per cycle through a shared fa8.
// Optional subtraction (A + ~B + 1) is enabled by defining ADD_SEQ_SUB_EN.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on acceptance
//   RUN   | one byte slice added per cycle, idx 0..WORDS-1
//   DONE  | result valid on S/cout, done pulses, back to IDLE
module add_seq
    import add_seq_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [8*WORDS-1:0] a,
    input  logic [8*WORDS-1:0] b,
    input  logic               ci,
`ifdef ADD_SEQ_SUB_EN
    input  logic               op,
`endif
    output logic               busy,
    output logic               done,
    output logic [8*WORDS-1:0] S,
    output logic               cout
);

    localparam int            IW       = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [8*WORDS-1:0] r_a;
    logic [8*WORDS-1:0] r_b;
    logic [8*WORDS-1:0] r_acc;
    logic [8*WORDS-1:0] r_s;
    logic [8*WORDS-1:0] w_acc_next;
    logic [8*WORDS-1:0] w_b_cap;
    logic [IW-1:0]      r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               w_ci_cap;
    logic               w_accept;
    logic               w_last;
    logic [7:0]         w_a_byte;
    logic [7:0]         w_b_byte;
    logic [7:0]         w_sum;
    logic               w_carry;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

`ifdef ADD_SEQ_SUB_EN
    // Subtraction is folded into capture: store ~B and force the initial carry.
    assign w_b_cap  = op ? ~b : b;
    assign w_ci_cap = op ? 1'b1 : ci;
`else
    assign w_b_cap  = b;
    assign w_ci_cap = ci;
`endif

    assign w_a_byte = r_a[8*r_idx +: 8];
    assign w_b_byte = r_b[8*r_idx +: 8];

    fa8 u_fa8 (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .ci   (r_carry),
        .S    (w_sum),
        .cout (w_carry)
    );

    always_comb begin
        w_acc_next              = r_acc;
        w_acc_next[8*r_idx +: 8] = w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = RUN;
            end
            RUN: begin
                if (r_idx == LAST_IDX) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // S/cout load from the merged accumulator on the last slice so they are
    // already valid in the DONE cycle; partial sums never reach S.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_cap;
            r_carry <= w_ci_cap;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_carry;
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                r_s    <= w_acc_next;
                r_cout <= w_carry;
            end
        end
    end

    assign S    = r_s;
    assign cout = r_cout;

endmodule
